// File: rtl/wbarb.sv
// Writeback arbiter: grants up to WPN valid result lanes per cycle across NSRC units
// (round-robin start, per-unit contiguous prefix) and registers them onto the writeback ports.
module wbarb #(
    parameter int NSRC   = 3,
    parameter int EWD    = 4,
    parameter int WPN    = 4,
    parameter int OPSZ   = 64,
    parameter int DATA_W = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [15:0]                         redir_opid_i,
    input  logic [15:0]                         redir_topid_i,
    input  logic [NSRC*EWD*(DATA_W+16)-1:0]     src_i,
    output logic [NSRC*EWD-1:0]                 claim_o,
    output logic [WPN*(DATA_W+16)-1:0]          wb_o
);

    // Bundle layout: {payload[DATA_W-1:0], opid[15:0]}, opid[15] = valid.
    localparam int BW = DATA_W + 16;
    localparam int AW = $clog2(OPSZ);
    localparam int NL = NSRC * EWD;
    localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [RW-1:0]       rr_q, rr_d;
    logic [WPN*BW-1:0]   wb_q, wb_d;
    logic [NL-1:0]       claim_d;

    // Younger than the redirect point within the age window; the +1 is kept one bit wider
    // so the redirecting op itself can never compare as killed.
    function automatic logic kill_f(input logic [15:0] x, input logic [15:0] r,
                                    input logic [15:0] t);
        logic [AW:0] dx;
        logic [AW:0] dr;
        dx = {1'b0, x[AW-1:0] - t[AW-1:0]};
        dr = {1'b0, r[AW-1:0] - t[AW-1:0]} + 1'b1;
        return r[15] & x[15] & (dx >= dr);
    endfunction

    // Valid lanes are taken in scan order until the ports are full; since grants stop only
    // when ports run out, each unit's grants are automatically a contiguous prefix.
    always_comb begin
        int cnt;
        int s;
        logic [BW-1:0] b;
        cnt     = 0;
        s       = 0;
        b       = '0;
        claim_d = '0;
        wb_d    = '0;
        rr_d    = rr_q;
        for (int k = 0; k < NSRC; k++) begin
            s = int'(rr_q) + k;
            if (s >= NSRC) s = s - NSRC;
            for (int l = 0; l < EWD; l++) begin
                b = src_i[(s*EWD+l)*BW +: BW];
                if (b[15] && (cnt < WPN)) begin
                    claim_d[s*EWD+l] = 1'b1;
                    if (kill_f(b[15:0], redir_opid_i, redir_topid_i)) b[15:0] = '0;
                    wb_d[cnt*BW +: BW] = b;
                    cnt = cnt + 1;
                end
            end
        end
        if (cnt != 0) rr_d = (rr_q == RW'(NSRC-1)) ? '0 : rr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            wb_q <= '0;
        end else begin
            rr_q <= rr_d;
            wb_q <= wb_d;
        end
    end

    assign claim_o = rst_ni ? claim_d : '0;

    // A redirect also blanks already-registered entries it squashes.
    always_comb begin
        wb_o = wb_q;
        for (int p = 0; p < WPN; p++) begin
            if (kill_f(wb_q[p*BW +: 16], redir_opid_i, redir_topid_i)) wb_o[p*BW +: 16] = '0;
        end
    end

endmodule

// File: tb/tb_wbarb.sv
// Bench for wbarb: queue-based reference model checked every cycle, plus directed literal cases.
module tb_wbarb;
    localparam int NSRC = 3, EWD = 4, WPN = 4, OPSZ = 64, DATA_W = 16;
    localparam int BW = DATA_W + 16;
    localparam int NL = NSRC * EWD;

    logic                 clk, rst_n;
    logic [15:0]          redir_opid, redir_topid;
    logic [NL*BW-1:0]     src;
    logic [NL-1:0]        claim;
    logic [WPN*BW-1:0]    wb;

    int nvec = 0;
    int nerr = 0;

    logic [WPN*BW-1:0]    m_wb;
    int                   m_rr;

    wbarb #(.NSRC(NSRC), .EWD(EWD), .WPN(WPN), .OPSZ(OPSZ), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .redir_opid_i(redir_opid), .redir_topid_i(redir_topid),
        .src_i(src), .claim_o(claim), .wb_o(wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int age(logic [15:0] x);
        return ((int'(x) - int'(redir_topid)) % OPSZ + OPSZ) % OPSZ;
    endfunction

    function automatic bit mkill(logic [15:0] x);
        return redir_opid[15] && x[15] && (age(x) > age(redir_opid));
    endfunction

    // Reference: list every valid lane in round-robin scan order; the first WPN win.
    function automatic void arb(output logic [NL-1:0] cl, output logic [WPN*BW-1:0] wbn,
                                output int ngr);
        int q[$];
        logic [BW-1:0] b;
        cl  = '0;
        wbn = '0;
        for (int k = 0; k < NSRC; k++) begin
            int s;
            s = (m_rr + k) % NSRC;
            for (int l = 0; l < EWD; l++)
                if (src[(s*EWD+l)*BW + 15]) q.push_back(s*EWD + l);
        end
        ngr = (q.size() < WPN) ? q.size() : WPN;
        for (int p = 0; p < ngr; p++) begin
            cl[q[p]] = 1'b1;
            b = src[q[p]*BW +: BW];
            if (mkill(b[15:0])) b[15:0] = 16'h0;
            wbn[p*BW +: BW] = b;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [NL-1:0] cl;
        logic [WPN*BW-1:0] wbn;
        int ngr;
        if (!rst_n) begin
            m_wb <= '0;
            m_rr <= 0;
        end else begin
            arb(cl, wbn, ngr);
            m_wb <= wbn;
            if (ngr > 0) m_rr <= (m_rr + 1) % NSRC;
        end
    end

    always @(negedge clk) begin
        logic [NL-1:0] cl;
        logic [WPN*BW-1:0] wbn;
        logic [BW-1:0] e, a;
        int ngr;
        arb(cl, wbn, ngr);
        if (!rst_n) cl = '0;
        nvec++;
        if (claim !== cl) begin
            nerr++;
            $display("FAIL model_claim t=%0t got=%h want=%h", $time, claim, cl);
        end
        for (int p = 0; p < WPN; p++) begin
            e = m_wb[p*BW +: BW];
            a = wb[p*BW +: BW];
            if (mkill(e[15:0])) e[15:0] = 16'h0;
            nvec++;
            if ((e[15] && a !== e) || (!e[15] && a[15:0] !== 16'h0)) begin
                nerr++;
                $display("FAIL model_wb%0d t=%0t got=%h want=%h", p, $time, a, e);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] wbop(int p);
        return wb[p*BW +: 16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        src = '0;
        redir_opid = 16'h0;
        redir_topid = 16'h0;
    endtask

    task automatic setl(int s, int l, logic [15:0] op);
        src[(s*EWD+l)*BW +: BW] = {op ^ 16'h5A5A, op};
    endtask

    task automatic rst_pulse();
        step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        for (int l = 0; l < EWD; l++) setl(0, l, 16'h8000 + 16'(l));
        #3;
        chk("reset_claim", 32'(claim), 32'h0);
        chk("reset_wb", 32'(wb == '0), 32'h1);
        step();
        rst_n = 1'b1;
        #1;
        chk("full_claim", 32'(claim), 32'h00F);
        step();
        for (int p = 0; p < WPN; p++) chk("full_wb", 32'(wbop(p)), 32'h8000 + 32'(p));

        // rr is now 1: source 1 leads the scan
        clr();
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < 3; l++) setl(s, l, 16'h8000 + 16'(s*16 + l));
        #1;
        chk("rr1_claim", 32'(claim), 32'h071);
        step();
        chk("rr1_wb0", 32'(wbop(0)), 32'h8010);
        chk("rr1_wb3", 32'(wbop(3)), 32'h8000);
        clr();
        setl(0, 1, 16'h8001);
        setl(0, 2, 16'h8002);
        #1;
        chk("rr2_claim", 32'(claim), 32'h006);

        rst_pulse();
        clr();
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < 3; l++) setl(s, l, 16'h8000 + 16'(s*16 + l));
        #1;
        chk("split_c1", 32'(claim), 32'h017);
        step();
        clr();
        setl(1, 1, 16'h8011);
        setl(1, 2, 16'h8012);
        #1;
        chk("split_c2", 32'(claim), 32'h060);

        rst_pulse();
        clr();
        setl(0, 0, 16'h8000);
        setl(0, 2, 16'h8002);
        #1;
        chk("skip_claim", 32'(claim), 32'h005);
        step();
        clr();
        #1;
        chk("skip_wb0", 32'(wbop(0)), 32'h8000);
        chk("skip_wb1", 32'(wbop(1)), 32'h8002);
        chk("skip_wb2", 32'(wbop(2)), 32'h0);

        rst_pulse();
        clr();
        setl(0, 0, 16'h8009);
        step();
        chk("sq_pre", 32'(wbop(0)), 32'h8009);
        clr();
        redir_opid = 16'h8005;
        redir_topid = 16'h8000;
        setl(0, 0, 16'h8003);
        setl(0, 1, 16'h8007);
        #1;
        chk("sq_claim", 32'(claim), 32'h003);
        chk("sq_blank", 32'(wbop(0)), 32'h0);
        step();
        clr();
        #1;
        chk("sq_wb0", 32'(wbop(0)), 32'h8003);
        chk("sq_wb1", 32'(wbop(1)), 32'h0);

        rst_pulse();
        clr();
        redir_opid = 16'h8001;
        redir_topid = 16'h803E;
        setl(0, 0, 16'h803F);
        setl(0, 1, 16'h8002);
        #1;
        chk("wrap_claim", 32'(claim), 32'h003);
        step();
        clr();
        #1;
        chk("wrap_wb0", 32'(wbop(0)), 32'h803F);
        chk("wrap_wb1", 32'(wbop(1)), 32'h0);

        rst_pulse();
        clr();
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < EWD; l++) setl(s, l, 16'h8000 + 16'(s*16 + l));
        step();
        chk("ar_pre", 32'(wbop(0)), 32'h8000);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wb", 32'(wb == '0), 32'h1);
        chk("ar_claim", 32'(claim), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_first", 32'(claim), 32'h00F);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] t;
            step();
            t = 16'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            redir_topid = t;
            redir_opid = {($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
                          15'(t + 16'($urandom_range(0, 40)))};
            src = '0;
            for (int s = 0; s < NSRC; s++)
                for (int l = 0; l < EWD; l++)
                    if ($urandom_range(0, 9) < 6)
                        src[(s*EWD+l)*BW +: BW] = {16'($urandom),
                                                   1'b1, 15'(t + 16'($urandom_range(0, 63)))};
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
